// File: rtl/merge_leaf_refill_scheduler_pkg.sv
// Shared types and helpers for the merge-tree leaf refill scheduler.
package merge_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sched_state_e;

    localparam int unsigned DEFAULT_BURST = 4;
    localparam int unsigned BURST_LEN_W   = $clog2(DEFAULT_BURST) + 1;

    function automatic int unsigned min_len(input int unsigned rem, input int unsigned burst);
        return (rem < burst) ? rem : burst;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin picker: first eligible leaf at or after the rotating pointer.
module rr_arbiter_n #(
    parameter int unsigned NUM_LEAVES = 4,
    parameter int unsigned LEAF_W     = 2
) (
    input  logic [NUM_LEAVES-1:0] i_elig,
    input  logic [LEAF_W-1:0]     i_rr_ptr,
    output logic [NUM_LEAVES-1:0] o_grant,
    output logic [LEAF_W-1:0]     o_idx,
    output logic                  o_any
);

    logic [LEAF_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_LEAVES; i++) begin
            // NUM_LEAVES is a power of two, so the LEAF_W-bit add wraps naturally.
            w_cand = i_rr_ptr + LEAF_W'(i);
            if (!o_any && i_elig[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/merge_leaf_refill_scheduler.sv
// Round-robin burst read scheduler feeding the leaf FIFOs of a 4-wide merge tree.
// A leaf is only requested when its FIFO credit guarantees room for the whole burst.
module merge_leaf_refill_scheduler
    import merge_sched_pkg::*;
#(
    parameter int unsigned NUM_LEAVES = 4,
    parameter int unsigned LEAF_W     = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 24,
    parameter int unsigned BURST      = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CRED_W     = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cfg_valid,
    input  logic [LEAF_W-1:0]          i_cfg_leaf,
    input  logic [ADDR_W-1:0]          i_cfg_addr,
    input  logic [LEN_W-1:0]           i_cfg_len,
    input  logic                       i_start,
    input  logic [NUM_LEAVES-1:0]      i_leaf_read,
    output logic                       o_req_valid,
    input  logic                       i_req_ready,
    output logic [ADDR_W-1:0]          o_req_addr,
    output logic [$clog2(BURST):0]     o_req_len,
    output logic [LEAF_W-1:0]          o_req_tag,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned RLEN_W = $clog2(BURST) + 1;

    sched_state_e r_state, w_state_next;

    logic [ADDR_W-1:0] r_ptr    [NUM_LEAVES];
    logic [LEN_W-1:0]  r_rem    [NUM_LEAVES];
    logic [CRED_W-1:0] r_credit [NUM_LEAVES];
    logic [LEAF_W-1:0] r_rr_ptr;

    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic [RLEN_W-1:0] r_req_len;
    logic [LEAF_W-1:0] r_req_tag;

    logic [RLEN_W-1:0]     w_need [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] w_elig;
    logic [NUM_LEAVES-1:0] w_grant_oh;
    logic [LEAF_W-1:0]     w_grant_idx;
    logic                  w_any;
    logic                  w_grant;
    logic                  w_cfg_we;
    logic                  w_all_zero;
    logic                  w_enter_run;

    always_comb begin
        w_all_zero = 1'b1;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            w_need[k] = RLEN_W'(min_len(32'(r_rem[k]), BURST));
            w_elig[k] = (r_rem[k] != '0) && (32'(r_credit[k]) >= 32'(w_need[k]));
            if (r_rem[k] != '0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    rr_arbiter_n #(
        .NUM_LEAVES (NUM_LEAVES),
        .LEAF_W     (LEAF_W)
    ) u_arb (
        .i_elig   (w_elig),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant_oh),
        .o_idx    (w_grant_idx),
        .o_any    (w_any)
    );

    // A new grant may land on the same edge that completes the current handshake.
    assign w_grant  = (r_state == StRun) && w_any && (!r_req_valid || i_req_ready);
    assign w_cfg_we = i_cfg_valid && (r_state != StRun);

    always_comb begin
        w_state_next = r_state;
        w_enter_run  = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_next = StRun;
                    w_enter_run  = 1'b1;
                end
            end
            StRun: begin
                if (w_all_zero && !r_req_valid) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_LEAVES; k++) begin
                r_ptr[k]    <= '0;
                r_rem[k]    <= '0;
                r_credit[k] <= CRED_W'(FIFO_DEPTH);
            end
            r_rr_ptr <= '0;
        end else begin
            for (int k = 0; k < NUM_LEAVES; k++) begin
                if (w_cfg_we && (i_cfg_leaf == LEAF_W'(k))) begin
                    r_ptr[k] <= i_cfg_addr;
                    r_rem[k] <= i_cfg_len;
                end else if (w_grant && w_grant_oh[k]) begin
                    r_ptr[k] <= r_ptr[k] + ADDR_W'(w_need[k]);
                    r_rem[k] <= r_rem[k] - LEN_W'(w_need[k]);
                end
                if (w_enter_run) begin
                    r_credit[k] <= CRED_W'(FIFO_DEPTH);
                end else if (r_state == StRun) begin
                    r_credit[k] <= r_credit[k] + CRED_W'(i_leaf_read[k])
                                 - ((w_grant && w_grant_oh[k]) ? CRED_W'(w_need[k]) : '0);
                end
            end
            if (w_grant) begin
                r_rr_ptr <= w_grant_idx + LEAF_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_len   <= '0;
            r_req_tag   <= '0;
        end else if (w_grant) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_ptr[w_grant_idx];
            r_req_len   <= w_need[w_grant_idx];
            r_req_tag   <= w_grant_idx;
        end else if (r_req_valid && i_req_ready) begin
            r_req_valid <= 1'b0;
        end
    end

    // A pop while credit already equals the FIFO depth means a word arrived that was never requested.
    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_credit_chk
        a_credit_bound : assert property (@(posedge i_clk) disable iff (i_rst)
            (r_state == StRun) |->
                (({1'b0, r_credit[g]} + (CRED_W + 1)'(i_leaf_read[g])) <= (CRED_W + 1)'(FIFO_DEPTH)));
    end

    assign o_req_valid = r_req_valid;
    assign o_req_addr  = r_req_addr;
    assign o_req_len   = r_req_len;
    assign o_req_tag   = r_req_tag;
    assign o_busy      = (r_state == StRun);
    assign o_done      = (r_state == StDone);

endmodule

// File: tb/tb_merge_leaf_refill_scheduler.sv
// Scoreboard bench for merge_leaf_refill_scheduler: expected requests queued at stimulus time.
module tb_merge_leaf_refill_scheduler;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_cfg_valid;
    logic [1:0]  i_cfg_leaf;
    logic [31:0] i_cfg_addr;
    logic [23:0] i_cfg_len;
    logic        i_start;
    logic [3:0]  i_leaf_read;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [31:0] o_req_addr;
    logic [2:0]  o_req_len;
    logic [1:0]  o_req_tag;
    logic        o_busy;
    logic        o_done;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  len;
        logic [1:0]  tag;
    } req_t;

    req_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    merge_leaf_refill_scheduler dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_cfg_valid (i_cfg_valid),
        .i_cfg_leaf  (i_cfg_leaf),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_len   (i_cfg_len),
        .i_start     (i_start),
        .i_leaf_read (i_leaf_read),
        .o_req_valid (o_req_valid),
        .i_req_ready (i_req_ready),
        .o_req_addr  (o_req_addr),
        .o_req_len   (o_req_len),
        .o_req_tag   (o_req_tag),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        i_cfg_valid = 1'b0;
        i_cfg_leaf  = '0;
        i_cfg_addr  = '0;
        i_cfg_len   = '0;
        i_start     = 1'b0;
        i_leaf_read = '0;
        i_req_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic cfg(input int leaf, input logic [31:0] addr, input int len);
        i_cfg_valid = 1'b1;
        i_cfg_leaf  = 2'(leaf);
        i_cfg_addr  = addr;
        i_cfg_len   = 24'(len);
        step();
        i_cfg_valid = 1'b0;
    endtask

    task automatic start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Waits (bounded) for a handshake and returns what was presented on it.
    task automatic wait_hs(input int budget, output bit ok, output req_t got);
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < budget; i++) begin
            if (o_req_valid && i_req_ready) begin
                ok  = 1'b1;
                got = {o_req_addr, o_req_len, o_req_tag};
                break;
            end
            step();
        end
        if (ok) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", o_req_valid); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++;
        if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", o_done); end
        checks++;
        if ({o_req_addr, o_req_len, o_req_tag} !== 37'd0) begin
            failures++;
            $display("FAIL reset_req: addr=%h len=%0d tag=%0d want all 0", o_req_addr, o_req_len, o_req_tag);
        end
    endtask

    task automatic test_round_robin();
        req_t got, exp;
        bit   ok;
        do_reset();
        i_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) cfg(k, 32'(32'h100 * (k + 1)), 8);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back({32'(32'h100 * (k + 1) + 4 * r), 3'd4, 2'(k)});
        start();
        for (int n = 0; n < 8; n++) begin
            wait_hs(20, ok, got);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rr_req%0d: no handshake within budget, required one", n);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rr_req%0d: addr=%h len=%0d tag=%0d want addr=%h len=%0d tag=%0d",
                             n, got.addr, got.len, got.tag, exp.addr, exp.len, exp.tag);
                end
            end
        end
        for (int i = 0; i < 5 && !o_done; i++) step();
        checks++;
        if (o_done !== 1'b1) begin failures++; $display("FAIL rr_done: got %b want 1", o_done); end
        checks++;
        if (o_req_valid !== 1'b0) begin failures++; $display("FAIL rr_no_extra: valid=%b want 0", o_req_valid); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut.r_credit[k] !== 5'd8 || dut.r_rem[k] !== 24'd0) begin
                failures++;
                $display("FAIL rr_state%0d: credit=%0d rem=%0d want credit=8 rem=0",
                         k, dut.r_credit[k], dut.r_rem[k]);
            end
        end
    endtask

    task automatic test_credit_stall();
        req_t got, exp;
        bit   ok;
        bit   seen;
        do_reset();
        i_req_ready = 1'b1;
        cfg(0, 32'h1000, 40);
        for (int n = 0; n < 4; n++) exp_q.push_back({32'(32'h1000 + 4 * n), 3'd4, 2'd0});
        start();
        for (int n = 0; n < 4; n++) begin
            wait_hs(20, ok, got);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL stall_req%0d: no handshake within budget, required one", n);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL stall_req%0d: addr=%h len=%0d tag=%0d want addr=%h len=%0d tag=%0d",
                             n, got.addr, got.len, got.tag, exp.addr, exp.len, exp.tag);
                end
            end
        end
        // This write lands in RUN and must have no effect.
        cfg(1, 32'h9000, 4);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (o_req_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin failures++; $display("FAIL stall_quiet: request seen while out of credit, want none"); end
        for (int i = 0; i < 4; i++) begin
            i_leaf_read = 4'b0001;
            step();
            i_leaf_read = 4'b0000;
            step();
        end
        exp_q.push_back({32'h1010, 3'd4, 2'd0});
        wait_hs(20, ok, got);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_refill: no handshake after credit return, required one");
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL stall_refill: addr=%h len=%0d tag=%0d want addr=%h len=%0d tag=%0d",
                         got.addr, got.len, got.tag, exp.addr, exp.len, exp.tag);
            end
        end
    endtask

    task automatic test_backpressure();
        req_t exp, cur;
        bit   stable;
        do_reset();
        cfg(1, 32'h2000, 12);
        for (int n = 0; n < 3; n++) exp_q.push_back({32'(32'h2000 + 4 * n), 3'd4, 2'd1});
        start();
        for (int i = 0; i < 5 && !o_req_valid; i++) step();
        checks++;
        if (o_req_valid !== 1'b1) begin failures++; $display("FAIL bp_first: valid=%b want 1", o_req_valid); end
        exp    = exp_q.pop_front();
        stable = 1'b1;
        cur    = '0;
        for (int i = 0; i < 5; i++) begin
            cur = {o_req_addr, o_req_len, o_req_tag};
            if (!o_req_valid || cur !== exp) stable = 1'b0;
            step();
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_hold: addr=%h len=%0d tag=%0d want addr=%h len=%0d tag=%0d held",
                     cur.addr, cur.len, cur.tag, exp.addr, exp.len, exp.tag);
        end
        i_req_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            step();
            exp = exp_q.pop_front();
            cur = {o_req_addr, o_req_len, o_req_tag};
            checks++;
            if (o_req_valid !== 1'b1 || cur !== exp) begin
                failures++;
                $display("FAIL bp_b2b%0d: valid=%b addr=%h len=%0d want valid=1 addr=%h len=%0d",
                         n, o_req_valid, cur.addr, cur.len, exp.addr, exp.len);
            end
        end
    endtask

    task automatic test_short_tail();
        req_t got, exp;
        bit   ok;
        bit   done_seen;
        do_reset();
        i_req_ready = 1'b1;
        // Config and start together: the config must be visible to RUN.
        i_cfg_valid = 1'b1;
        i_cfg_leaf  = 2'd2;
        i_cfg_addr  = 32'h3000;
        i_cfg_len   = 24'd6;
        i_start     = 1'b1;
        step();
        i_cfg_valid = 1'b0;
        i_start     = 1'b0;
        exp_q.push_back({32'h3000, 3'd4, 2'd2});
        exp_q.push_back({32'h3004, 3'd2, 2'd2});
        for (int n = 0; n < 2; n++) begin
            wait_hs(20, ok, got);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL tail_req%0d: no handshake within budget, required one", n);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL tail_req%0d: addr=%h len=%0d tag=%0d want addr=%h len=%0d tag=%0d",
                             n, got.addr, got.len, got.tag, exp.addr, exp.len, exp.tag);
                end
            end
        end
        done_seen = o_done;
        if (!done_seen) begin
            step();
            done_seen = o_done;
        end
        checks++;
        if (!done_seen) begin failures++; $display("FAIL tail_done: o_done=%b want 1", o_done); end
        checks++;
        if (o_req_valid !== 1'b0) begin failures++; $display("FAIL tail_idle: valid=%b want 0", o_req_valid); end
    endtask

    task automatic test_zero_len();
        do_reset();
        i_req_ready = 1'b1;
        start();
        checks++;
        if (o_busy !== 1'b1 || o_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy: busy=%b valid=%b want busy=1 valid=0", o_busy, o_req_valid);
        end
        step();
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done=%b busy=%b valid=%b want 1 0 0", o_done, o_busy, o_req_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cfg(3, 32'h4000, 8);
        start();
        for (int i = 0; i < 5 && !o_req_valid; i++) step();
        checks++;
        if (o_req_valid !== 1'b1) begin failures++; $display("FAIL mr_pending: valid=%b want 1", o_req_valid); end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        checks++;
        if (o_req_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL mr_cleared: valid=%b busy=%b done=%b want 0 0 0", o_req_valid, o_busy, o_done);
        end
        start();
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL mr_restart: busy=%b want 1", o_busy); end
        step();
        checks++;
        if (o_done !== 1'b1 || o_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL mr_done: done=%b valid=%b want done=1 valid=0", o_done, o_req_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_stall();
        test_backpressure();
        test_short_tail();
        test_zero_len();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
